// File: rtl/general_pack.sv
// -----------------------------------------------------------------------------
// general_pack
// Shared types and helpers for the Avalon-ST packetizer slice.
//   avalon_packetizer_sm_t : packetizer control state (IDLE / SEND)
//   empty_width()          : width of the Avalon-ST 'empty' field for a given
//                            stream word width in bytes (never below 1 bit)
// -----------------------------------------------------------------------------
package general_pack;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } avalon_packetizer_sm_t;

    function automatic int empty_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// -----------------------------------------------------------------------------
// avalon_st_if
// Avalon-ST framed stream bundle.
//   data  : DATA_WIDTH_IN_BYTES*8 payload word
//   valid : word present
//   sop   : first word of a packet
//   eop   : last word of a packet
//   empty : number of unused low-order bytes on the eop word
//   rdy   : sink accepts the word when valid and rdy are both high
// Modports: master (source side), slave (sink side).
// -----------------------------------------------------------------------------
interface avalon_st_if
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);

    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;
    logic                             rdy;

    modport master (output data, valid, sop, eop, empty, input  rdy);
    modport slave  (input  data, valid, sop, eop, empty, output rdy);

endinterface

// File: rtl/avalon_empty_masker.sv
// -----------------------------------------------------------------------------
// avalon_empty_masker
// Combinational tail-byte zeroing for the last word of a packet.
//   data   : input word
//   empty  : number of low-order bytes to clear (0 = pass through)
//   masked : data with bytes [empty-1:0] forced to zero, upper bytes unchanged
// -----------------------------------------------------------------------------
module avalon_empty_masker #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int EMPTY_W             = 4
) (
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] data,
    input  logic [EMPTY_W-1:0]               empty,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0] masked
);

    always_comb begin
        for (int i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
            masked[i*8 +: 8] = (i < int'(empty)) ? 8'h00 : data[i*8 +: 8];
        end
    end

endmodule

// File: rtl/avalon_packetizer.sv
// -----------------------------------------------------------------------------
// avalon_packetizer
// Frames a raw payload word stream into Avalon-ST packets. A command gives the
// message length in bytes; the block then takes ceil(len/DATA_WIDTH_IN_BYTES)
// payload words and emits them with sop/eop/empty, one register stage deep.
//
// Ports
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   cmd_valid/rdy  : command handshake, cmd_len = message length in bytes
//   data_in_valid/rdy, data_in : raw payload word handshake
//   msg_out        : avalon_st_if.master framed output
//   zero_len_err   : one-cycle pulse after a zero-length command is accepted
//   msg_cnt        : (only with AVALON_PACKETIZER_STATS_EN) count of accepted
//                    eop words, 32 bits, wrapping
//
// Build option: define AVALON_PACKETIZER_STATS_EN to add msg_cnt.
// -----------------------------------------------------------------------------
module avalon_packetizer #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    input  logic [LEN_WIDTH-1:0]             cmd_len,
    output logic                             cmd_rdy,
    input  logic                             data_in_valid,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] data_in,
    output logic                             data_in_rdy,
    avalon_st_if.master                      msg_out,
    output logic                             zero_len_err
`ifdef AVALON_PACKETIZER_STATS_EN
    ,
    output logic [31:0]                      msg_cnt
`endif
);
    import general_pack::*;

    localparam int                   DATA_W  = DATA_WIDTH_IN_BYTES * 8;
    localparam int                   EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);
    localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(DATA_WIDTH_IN_BYTES);
    localparam logic [LEN_WIDTH-1:0] ONE_L   = LEN_WIDTH'(1);

    avalon_packetizer_sm_t state_q, state_d;

    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] words_left_q;
    logic [LEN_WIDTH-1:0] words_init;
    logic [LEN_WIDTH-1:0] tail_bytes;
    logic                 first_q;
    logic                 cmd_fire;
    logic                 in_fire;
    logic                 last_word;
    logic [EMPTY_W-1:0]   last_empty;
    logic [EMPTY_W-1:0]   mask_empty;
    logic [DATA_W-1:0]    masked_data;

    logic [DATA_W-1:0]    out_data_q;
    logic                 out_valid_q;
    logic                 out_sop_q;
    logic                 out_eop_q;
    logic [EMPTY_W-1:0]   out_empty_q;

    // Handshakes. The output stage may take a new word whenever it is empty
    // or its current word leaves this cycle.
    assign cmd_rdy     = (state_q == IDLE);
    assign data_in_rdy = (state_q == SEND) && (!out_valid_q || msg_out.rdy);
    assign cmd_fire    = cmd_valid && cmd_rdy;
    assign in_fire     = data_in_valid && data_in_rdy;

    // ceil(cmd_len / bytes) without a wider adder.
    assign words_init = (cmd_len / BYTES_L) + (((cmd_len % BYTES_L) != '0) ? ONE_L : '0);

    // Unused bytes on the eop word, derived from the latched length.
    assign tail_bytes = len_q % BYTES_L;
    assign last_empty = (tail_bytes == '0) ? '0 : EMPTY_W'(BYTES_L - tail_bytes);

    assign last_word  = (words_left_q == ONE_L);
    assign mask_empty = last_word ? last_empty : '0;

    avalon_empty_masker #(
        .DATA_WIDTH_IN_BYTES (DATA_WIDTH_IN_BYTES),
        .EMPTY_W             (EMPTY_W)
    ) u_masker (
        .data   (data_in),
        .empty  (mask_empty),
        .masked (masked_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d takes a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire && (cmd_len != '0)) state_d = SEND;
            SEND:    if (in_fire && last_word)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the output data register is reset as well, because the stream
    // must read all-zero while rst is high; it is one word, not a memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= '0;
            words_left_q <= '0;
            first_q      <= 1'b0;
            zero_len_err <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_empty_q  <= '0;
        end else begin
            zero_len_err <= cmd_fire && (cmd_len == '0);

            if (cmd_fire) begin
                len_q        <= cmd_len;
                words_left_q <= words_init;
                first_q      <= 1'b1;
            end

            // in_fire implies words_left_q >= 1, so the counter cannot wrap.
            if (in_fire) begin
                words_left_q <= words_left_q - ONE_L;
                first_q      <= 1'b0;
                out_data_q   <= masked_data;
                out_valid_q  <= 1'b1;
                out_sop_q    <= first_q;
                out_eop_q    <= last_word;
                out_empty_q  <= mask_empty;
            end else if (msg_out.rdy) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign msg_out.data  = out_data_q;
    assign msg_out.valid = out_valid_q;
    assign msg_out.sop   = out_sop_q;
    assign msg_out.eop   = out_eop_q;
    assign msg_out.empty = out_empty_q;

`ifdef AVALON_PACKETIZER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_cnt <= '0;
        end else if (out_valid_q && msg_out.rdy && out_eop_q) begin
            msg_cnt <= msg_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_packetizer.sv
// -----------------------------------------------------------------------------
// tb_avalon_packetizer
// Self-checking bench for avalon_packetizer (DATA_WIDTH_IN_BYTES=16).
// Drives inputs on the falling edge, samples 1 ns later, and compares the
// accepted output beats with a packet-level reference model.
// Build option: AVALON_PACKETIZER_STATS_EN enables the msg_cnt checks.
// -----------------------------------------------------------------------------
module tb_avalon_packetizer;

    localparam int DW      = 16;
    localparam int LW      = 16;
    localparam int BW      = DW * 8;
    localparam int EW      = 4;
    localparam int TIMEOUT = 200;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    typedef struct {
        int len;
        int words;
        int empty;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic [LW-1:0] cmd_len;
    logic          cmd_rdy;
    logic          data_in_valid;
    logic [BW-1:0] data_in;
    logic          data_in_rdy;
    logic          zero_len_err;
`ifdef AVALON_PACKETIZER_STATS_EN
    logic [31:0]   msg_cnt;
`endif

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) st ();

    avalon_packetizer #(
        .DATA_WIDTH_IN_BYTES (DW),
        .LEN_WIDTH           (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_len       (cmd_len),
        .cmd_rdy       (cmd_rdy),
        .data_in_valid (data_in_valid),
        .data_in       (data_in),
        .data_in_rdy   (data_in_rdy),
        .msg_out       (st),
        .zero_len_err  (zero_len_err)
`ifdef AVALON_PACKETIZER_STATS_EN
        ,
        .msg_cnt       (msg_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    zle_seen = 0;
    int    zle_exp  = 0;
    bit    rand_rdy = 0;
    bit    held     = 0;
    beat_t held_beat;
    beat_t out_q[$];
    beat_t exp_q[$];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: word k of a len-byte message, straight from the framing rules.
    function automatic beat_t model_beat(input int len, input int k, input logic [BW-1:0] d);
        beat_t b;
        int    nw;
        int    unused;
        nw      = (len + DW - 1) / DW;
        unused  = nw * DW - len;
        b.data  = d;
        b.sop   = (k == 0);
        b.eop   = (k == nw - 1);
        b.empty = '0;
        if (b.eop) begin
            b.empty = EW'(unused);
            for (int i = 0; i < unused; i++) b.data[i*8 +: 8] = 8'h00;
        end
        return b;
    endfunction

    // One clock: sample handshakes at drive+1ns, record accepted output
    // beats, check hold-stability, then advance to the next falling edge.
    task automatic cycle(output bit c_acc, output bit d_acc);
        beat_t cur;
        #1;
        c_acc     = cmd_valid && cmd_rdy;
        d_acc     = data_in_valid && data_in_rdy;
        cur.data  = st.data;
        cur.sop   = st.sop;
        cur.eop   = st.eop;
        cur.empty = st.empty;
        if (zero_len_err) zle_seen++;
        if (held && !rst) begin
            check("hold_data", cur.data, held_beat.data);
            check("hold_ctrl", BW'({st.valid, cur.sop, cur.eop, cur.empty}),
                  BW'({1'b1, held_beat.sop, held_beat.eop, held_beat.empty}));
        end
        if (st.valid && st.rdy) out_q.push_back(cur);
        held      = st.valid && !st.rdy && !rst;
        held_beat = cur;
        @(posedge clk);
        @(negedge clk);
        if (rand_rdy) st.rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_msg(input int len, input bit gaps);
        bit            c, d;
        int            guard;
        int            nw;
        logic [BW-1:0] w;
        nw        = (len + DW - 1) / DW;
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        guard     = 0;
        do begin
            cycle(c, d);
            guard++;
        end while (!c && guard < TIMEOUT);
        cmd_valid = 1'b0;
        check("cmd_accept", BW'(c), BW'(1));
        if (!c) return;
        if (len == 0) zle_exp++;
        for (int k = 0; k < nw; k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(model_beat(len, k, w));
            data_in = w;
            guard   = 0;
            do begin
                data_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                cycle(c, d);
                guard++;
            end while (!d && guard < TIMEOUT);
            data_in_valid = 1'b0;
            check("data_accept", BW'(d), BW'(1));
            if (!d) return;
        end
    endtask

    task automatic drain();
        bit c, d;
        int guard;
        rand_rdy = 0;
        st.rdy   = 1'b1;
        guard    = 0;
        do begin
            cycle(c, d);
            guard++;
        end while (st.valid && guard < TIMEOUT);
        check("drain_valid_clear", BW'(st.valid), '0);
    endtask

    task automatic compare_streams(input string tag);
        check($sformatf("%s_beat_count", tag), BW'(out_q.size()), BW'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d_data", tag, i), out_q[i].data, exp_q[i].data);
            check($sformatf("%s_w%0d_ctrl", tag, i),
                  BW'({out_q[i].sop, out_q[i].eop, out_q[i].empty}),
                  BW'({exp_q[i].sop, exp_q[i].eop, exp_q[i].empty}));
        end
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic verify_vector(input string tag, input int words, input int empty);
        logic [BW-1:0] low_mask;
        beat_t         last;
        check({tag, "_words"}, BW'(out_q.size()), BW'(words));
        if (out_q.size() == words && words > 0) begin
            last     = out_q[words-1];
            low_mask = '0;
            for (int i = 0; i < empty; i++) low_mask[i*8 +: 8] = 8'hff;
            check({tag, "_first_sop"}, BW'(out_q[0].sop), BW'(1));
            check({tag, "_last_eop"},  BW'(last.eop), BW'(1));
            check({tag, "_last_empty"}, BW'(last.empty), BW'(empty));
            check({tag, "_low_bytes_zero"}, last.data & low_mask, '0);
        end
        compare_streams(tag);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, BW'(st.valid), '0);
        check({tag, "_sop_eop_empty"}, BW'({st.sop, st.eop, st.empty}), '0);
        check({tag, "_data"}, st.data, '0);
        check({tag, "_zero_len_err"}, BW'(zero_len_err), '0);
        check({tag, "_cmd_rdy"}, BW'(cmd_rdy), BW'(1));
        check({tag, "_data_in_rdy"}, BW'(data_in_rdy), '0);
    endtask

    initial begin
        vec_t          vecs[7];
        bit            c, d;
        int            len;
        int            eops;
        logic [BW-1:0] w2;

        vecs[0] = '{40, 3, 8};
        vecs[1] = '{16, 1, 0};
        vecs[2] = '{17, 2, 15};
        vecs[3] = '{1, 1, 15};
        vecs[4] = '{32, 2, 0};
        vecs[5] = '{15, 1, 1};
        vecs[6] = '{33, 3, 15};

        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_len       = '0;
        data_in_valid = 1'b0;
        data_in       = '0;
        st.rdy        = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        cycle(c, d);

        // Table-driven single messages with the sink always ready.
        for (int i = 0; i < 7; i++) begin
            send_msg(vecs[i].len, 1'b0);
            drain();
            verify_vector($sformatf("vec%0d_len%0d", i, vecs[i].len), vecs[i].words, vecs[i].empty);
        end

        // Zero-length command: one error pulse, no output, stays idle.
        cmd_valid = 1'b1;
        cmd_len   = '0;
        cycle(c, d);
        cmd_valid = 1'b0;
        check("zl_accept", BW'(c), BW'(1));
        check("zl_err_pulse", BW'(zero_len_err), BW'(1));
        check("zl_valid", BW'(st.valid), '0);
        check("zl_cmd_rdy", BW'(cmd_rdy), BW'(1));
        cycle(c, d);
        check("zl_err_cleared", BW'(zero_len_err), '0);
        check("zl_valid_after", BW'(st.valid), '0);
        check("zl_idle_after", BW'({cmd_rdy, data_in_rdy}), BW'(2'b10));
        out_q.delete();

        // len=48 with the sink stalled for 3 cycles while word 2 is held.
        cmd_valid = 1'b1;
        cmd_len   = LW'(48);
        cycle(c, d);
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(model_beat(48, k, data_in));
            data_in_valid = 1'b1;
            cycle(c, d);
            check($sformatf("stall_w%0d_accept", k), BW'(d), BW'(1));
        end
        w2      = data_in;
        st.rdy  = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(model_beat(48, 2, data_in));
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall_c%0d_data", k), st.data, w2);
            check($sformatf("stall_c%0d_ctrl", k), BW'({st.valid, st.sop, st.eop, st.empty}), BW'(7'b1000000));
            check($sformatf("stall_c%0d_din_rdy", k), BW'(data_in_rdy), '0);
            check($sformatf("stall_c%0d_cmd_rdy", k), BW'(cmd_rdy), '0);
            cycle(c, d);
        end
        st.rdy = 1'b1;
        cycle(c, d);
        check("stall_w2_accept", BW'(d), BW'(1));
        data_in_valid = 1'b0;
        cycle(c, d);
        check("stall_valid_clear", BW'(st.valid), '0);
        check("stall_words", BW'(out_q.size()), BW'(3));
        compare_streams("stall48");

        // Reset in the middle of a len=48 message, then len=17.
        cmd_valid = 1'b1;
        cmd_len   = LW'(48);
        cycle(c, d);
        cmd_valid     = 1'b0;
        data_in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            cycle(c, d);
        end
        data_in_valid = 1'b0;
        check("mid_w2_valid", BW'(st.valid), BW'(1));
        rst = 1'b1;
        #1;
        check_idle("mid_rst");
        cycle(c, d);
        check_idle("mid_rst_hold");
        eops = 0;
        foreach (out_q[i]) if (out_q[i].eop) eops++;
        check("mid_rst_no_eop", BW'(eops), '0);
        out_q.delete();
        exp_q.delete();
        rst = 1'b0;
        cycle(c, d);
        send_msg(17, 1'b0);
        drain();
        verify_vector("after_rst_len17", 2, 15);

`ifdef AVALON_PACKETIZER_STATS_EN
        rst = 1'b1;
        cycle(c, d);
        rst = 1'b0;
        cycle(c, d);
        check("stats_reset", BW'(msg_cnt), '0);
        send_msg(5, 1'b0);
        send_msg(20, 1'b0);
        send_msg(33, 1'b0);
        drain();
        check("stats_msg_cnt", BW'(msg_cnt), BW'(3));
        compare_streams("stats");
`endif

        // Randomized traffic: random lengths (some zero), input gaps and
        // sink backpressure, compared with the reference model.
        out_q.delete();
        exp_q.delete();
        zle_seen = 0;
        zle_exp  = 0;
        rand_rdy = 1;
        for (int m = 0; m < 40; m++) begin
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 80));
            send_msg(len, 1'b1);
        end
        drain();
        compare_streams("rand");
        check("rand_zero_len_pulses", BW'(zle_seen), BW'(zle_exp));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/avalon_packetizer.md
AVALON_PACKETIZER -- requirements
Module: avalon_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_IN_BYTES, default 16, meaning the byte width of one stream word.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, meaning the width of the message length field in bytes.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  a message command is offered.
REQ-006 SHALL have port cmd_len  input  LEN_WIDTH  message length in bytes.
REQ-007 SHALL have port cmd_rdy  output  1  the command is accepted when cmd_valid and cmd_rdy are both high.
REQ-008 SHALL have port data_in_valid  input  1  a raw payload word is offered.
REQ-009 SHALL have port data_in  input  DATA_WIDTH_IN_BYTES*8  raw payload word.
REQ-010 SHALL have port data_in_rdy  output  1  the payload word is accepted when data_in_valid and data_in_rdy are both high.
REQ-011 SHALL have port msg_out  avalon_st_if.master  -  framed output stream carrying data, valid, sop, eop, empty and rdy.
REQ-012 SHALL have port zero_len_err  output  1  one-cycle pulse when a zero-length command is accepted.

Function
REQ-013 SHALL implement the states IDLE and SEND.
REQ-014 In IDLE, cmd_rdy SHALL be 1; in SEND, cmd_rdy SHALL be 0.
REQ-015 A command accepted with cmd_len=0 SHALL pulse zero_len_err for one cycle, produce no output, and leave the block in IDLE.
REQ-016 A command accepted with cmd_len>0 SHALL move IDLE->SEND, latch cmd_len, and load a word counter with ceil(cmd_len/DATA_WIDTH_IN_BYTES).
REQ-017 data_in_rdy SHALL equal (state==SEND) and (!msg_out.valid or msg_out.rdy).
REQ-018 Each accepted payload word SHALL appear on msg_out registered on the next clock edge with msg_out.valid=1, giving a latency of 1 cycle.
REQ-019 The first word of each message SHALL carry sop=1; all other words SHALL carry sop=0.
REQ-020 The last word SHALL carry eop=1 and empty=DATA_WIDTH_IN_BYTES*words-cmd_len; empty and eop SHALL be 0 on every other word.
REQ-021 On the last word, bytes [empty-1:0] SHALL be forced to zero; the upper bytes SHALL carry payload.
REQ-022 A message of exactly one word SHALL carry sop=1 and eop=1 on the same word.
REQ-023 Acceptance of the last word SHALL move SEND->IDLE; the next command SHALL be accepted no earlier than the following cycle.
REQ-024 While msg_out.valid=1 and msg_out.rdy=0, all msg_out fields SHALL hold stable.
REQ-025 msg_out.valid SHALL clear when the held word is accepted and no new payload word is accepted in the same cycle.
REQ-026 empty SHALL be $clog2(DATA_WIDTH_IN_BYTES) bits wide; the word counter SHALL be LEN_WIDTH bits wide and SHALL never wrap.

Reset
REQ-027 While rst=1, the block SHALL force state=IDLE, msg_out.valid/sop/eop/empty/data=0, zero_len_err=0, and clear the counters.
REQ-028 A reset mid-message SHALL abandon the message without emitting eop, and the next message after reset SHALL begin with sop.

Configuration
REQ-029 With AVALON_PACKETIZER_STATS_EN defined, the block SHALL add output msg_cnt, 32 bits wide, reset to 0, incremented on each accepted eop word and wrapping at 2^32.
REQ-030 Without AVALON_PACKETIZER_STATS_EN, the msg_cnt port and its logic SHALL be absent.

Structure
REQ-031 The state enum type avalon_packetizer_sm_t SHALL reside in general_pack.
REQ-032 The tail-byte zeroing on the last word (data, empty -> masked data) SHALL be a combinational sub-module named avalon_empty_masker.

Verification (DATA_WIDTH_IN_BYTES=16)
REQ-033 The bench SHALL cover: cmd_len=40, rdy=1 -> 3 words; sop on word 1; eop and empty=8 on word 3; word-3 bytes 7:0 = 0.
REQ-034 The bench SHALL cover: cmd_len=16 -> a single word with sop=1, eop=1, empty=0.
REQ-035 The bench SHALL cover: cmd_len=0 -> zero_len_err=1 for 1 cycle, msg_out.valid stays 0, block stays in IDLE.
REQ-036 The bench SHALL cover: cmd_len=48 with msg_out.rdy=0 for 3 cycles on word 2 -> word 2 fields stable for those cycles, data_in_rdy=0, and 3 words total.
REQ-037 The bench SHALL cover: rst asserted during word 2 of cmd_len=48, then cmd_len=17 -> outputs 0 during reset; then 2 words with sop on word 1, eop and empty=15 on word 2.
REQ-038 With AVALON_PACKETIZER_STATS_EN defined, the bench SHALL send 3 messages and check msg_cnt=3.
